axi_stream_header_arbiter: RTL and testbench

Packet-level arbiter that shares one `axi_stream_insert_header` instance between NUM_SRC requester ports. Each requester presents a header channel (insert) and a data channel (in). The arbiter grants one requester at a time, round-robin. It routes that requester's header beat and complete data packet to the shared insert block. The grant is held until both the header handshake and the data `last` handshake have completed. The block sits directly upstream of `axi_stream_insert_header` and shares its clock and reset.

---
 rtl/axi_stream_header_arbiter.sv | 171 +++++++++++++++++
 tb/tb_axi_stream_header_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_header_arbiter.sv
// Packet-level arbiter sharing one axi_stream_insert_header between NUM_SRC requesters.
// Build option: define AXIS_HDR_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module axi_stream_header_arbiter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int NUM_SRC      = 4,
    parameter int GRANT_WD     = $clog2(NUM_SRC)
) (
    input  logic                              clk,
    input  logic                              rst_n,

    input  logic [NUM_SRC-1:0]                s_valid_in,
    input  logic [NUM_SRC*DATA_WD-1:0]        s_data_in,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep_in,
    input  logic [NUM_SRC-1:0]                s_last_in,
    output logic [NUM_SRC-1:0]                s_ready_in,

    input  logic [NUM_SRC-1:0]                s_valid_insert,
    input  logic [NUM_SRC*DATA_WD-1:0]        s_data_insert,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep_insert,
    input  logic [NUM_SRC*BYTE_CNT_WD-1:0]    s_byte_insert_cnt,
    output logic [NUM_SRC-1:0]                s_ready_insert,

    output logic                              valid_in,
    output logic [DATA_WD-1:0]                data_in,
    output logic [DATA_BYTE_WD-1:0]           keep_in,
    output logic                              last_in,
    input  logic                              ready_in,

    output logic                              valid_insert,
    output logic [DATA_WD-1:0]                data_insert,
    output logic [DATA_BYTE_WD-1:0]           keep_insert,
    output logic [BYTE_CNT_WD-1:0]            byte_insert_cnt,
    input  logic                              ready_insert,

    output logic                              grant_valid,
    output logic [GRANT_WD-1:0]               grant_id
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                  state_reg, state_next;
    logic [GRANT_WD-1:0]     grant_id_reg, grant_id_next;
    logic                    hdr_done_reg, hdr_done_next;
    logic                    dat_done_reg, dat_done_next;
    logic [GRANT_WD-1:0]     winner;
    logic                    req_any;
    logic                    hdr_hs;
    logic                    dat_last_hs;

    logic [DATA_WD-1:0]      src_data     [NUM_SRC];
    logic [DATA_BYTE_WD-1:0] src_keep     [NUM_SRC];
    logic [DATA_WD-1:0]      src_hdr_data [NUM_SRC];
    logic [DATA_BYTE_WD-1:0] src_hdr_keep [NUM_SRC];
    logic [BYTE_CNT_WD-1:0]  src_hdr_cnt  [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign src_data[gi]     = s_data_in[gi*DATA_WD +: DATA_WD];
            assign src_keep[gi]     = s_keep_in[gi*DATA_BYTE_WD +: DATA_BYTE_WD];
            assign src_hdr_data[gi] = s_data_insert[gi*DATA_WD +: DATA_WD];
            assign src_hdr_keep[gi] = s_keep_insert[gi*DATA_BYTE_WD +: DATA_BYTE_WD];
            assign src_hdr_cnt[gi]  = s_byte_insert_cnt[gi*BYTE_CNT_WD +: BYTE_CNT_WD];
        end
    endgenerate

    assign req_any = |s_valid_insert;

`ifdef AXIS_HDR_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest requesting index is the last assignment.
    always_comb begin
        winner = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (s_valid_insert[k]) winner = GRANT_WD'(k);
        end
    end
`else
    logic [GRANT_WD-1:0] rr_ptr_reg, rr_ptr_next;
    logic [GRANT_WD:0]   rr_sum;
    logic [GRANT_WD-1:0] rr_idx;

    // Scan offsets from rr_ptr downwards so the nearest requester after rr_ptr wins.
    always_comb begin
        winner = '0;
        rr_sum = '0;
        rr_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            rr_sum = {1'b0, rr_ptr_reg} + (GRANT_WD+1)'(k);
            if (rr_sum >= (GRANT_WD+1)'(NUM_SRC)) rr_sum = rr_sum - (GRANT_WD+1)'(NUM_SRC);
            rr_idx = rr_sum[GRANT_WD-1:0];
            if (s_valid_insert[rr_idx]) winner = rr_idx;
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (state_reg == IDLE && req_any) begin
            rr_ptr_next = (winner == GRANT_WD'(NUM_SRC - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_reg <= '0;
        else        rr_ptr_reg <= rr_ptr_next;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            grant_id_reg <= '0;
            hdr_done_reg <= 1'b0;
            dat_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_id_reg <= grant_id_next;
            hdr_done_reg <= hdr_done_next;
            dat_done_reg <= dat_done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        grant_id_next = grant_id_reg;
        hdr_done_next = hdr_done_reg;
        dat_done_next = dat_done_reg;
        case (state_reg)
            IDLE: begin
                if (req_any) begin
                    state_next    = BUSY;
                    grant_id_next = winner;
                    hdr_done_next = 1'b0;
                    dat_done_next = 1'b0;
                end
            end
            BUSY: begin
                hdr_done_next = hdr_done_reg | hdr_hs;
                dat_done_next = dat_done_reg | dat_last_hs;
                // Release on the edge where the final outstanding completion lands.
                if (hdr_done_next && dat_done_next) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        valid_in        = 1'b0;
        valid_insert    = 1'b0;
        s_ready_in      = '0;
        s_ready_insert  = '0;
        data_in         = src_data[grant_id_reg];
        keep_in         = src_keep[grant_id_reg];
        last_in         = s_last_in[grant_id_reg];
        data_insert     = src_hdr_data[grant_id_reg];
        keep_insert     = src_hdr_keep[grant_id_reg];
        byte_insert_cnt = src_hdr_cnt[grant_id_reg];
        if (state_reg == BUSY) begin
            valid_insert                 = s_valid_insert[grant_id_reg] & ~hdr_done_reg;
            s_ready_insert[grant_id_reg] = ready_insert & ~hdr_done_reg;
            valid_in                     = s_valid_in[grant_id_reg] & ~dat_done_reg;
            s_ready_in[grant_id_reg]     = ready_in & ~dat_done_reg;
        end
    end

    assign hdr_hs      = valid_insert & ready_insert;
    assign dat_last_hs = valid_in & ready_in & last_in;
    assign grant_valid = (state_reg == BUSY);
    assign grant_id    = grant_id_reg;

endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// Scoreboard bench for axi_stream_header_arbiter: per-source expected queues checked by a negedge monitor
// against a transaction-level arbitration model.
module tb_axi_stream_header_arbiter;

    localparam int DW = 32;
    localparam int BW = 4;
    localparam int CW = 2;
    localparam int NS = 4;
    localparam int GW = 2;

    typedef struct packed {logic [DW-1:0] d; logic [BW-1:0] k; logic l;} beat_t;
    typedef struct packed {logic [DW-1:0] d; logic [BW-1:0] k; logic [CW-1:0] c;} hdr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NS-1:0]    s_valid_in = '0, s_last_in = '0, s_ready_in;
    logic [NS*DW-1:0] s_data_in = '0, s_data_insert = '0;
    logic [NS*BW-1:0] s_keep_in = '0, s_keep_insert = '0;
    logic [NS*CW-1:0] s_byte_insert_cnt = '0;
    logic [NS-1:0]    s_valid_insert = '0, s_ready_insert;
    logic valid_in, last_in, valid_insert, grant_valid;
    logic ready_in = 1'b1, ready_insert = 1'b1;
    logic [DW-1:0] data_in, data_insert;
    logic [BW-1:0] keep_in, keep_insert;
    logic [CW-1:0] byte_insert_cnt;
    logic [GW-1:0] grant_id;

    axi_stream_header_arbiter #(.DATA_WD(DW), .NUM_SRC(NS)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid_in(s_valid_in), .s_data_in(s_data_in), .s_keep_in(s_keep_in),
        .s_last_in(s_last_in), .s_ready_in(s_ready_in),
        .s_valid_insert(s_valid_insert), .s_data_insert(s_data_insert),
        .s_keep_insert(s_keep_insert), .s_byte_insert_cnt(s_byte_insert_cnt),
        .s_ready_insert(s_ready_insert),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in),
        .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
        .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    beat_t drv_beat_q [NS][$];
    hdr_t  drv_hdr_q  [NS][$];
    beat_t exp_beat_q [NS][$];
    hdr_t  exp_hdr_q  [NS][$];
    int    grant_log [$];

    int gap_pct = 0;
    int rin_pct = 100;
    int rins_pct = 100;
    logic rins_block = 1'b0;

    // Transaction-level model of the arbiter.
    logic m_busy = 1'b0, m_new = 1'b0, m_hdr_done = 1'b0, m_dat_done = 1'b0;
    int   m_gid = 0, m_rr = 0, m_beats = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(logic [NS-1:0] req, int ptr);
        int p;
        p = ptr;
`ifdef AXIS_HDR_ARB_FIXED_PRIO_EN
        p = 0;
`endif
        for (int k = 0; k < NS; k++) if (req[(p + k) % NS]) return (p + k) % NS;
        return 0;
    endfunction

    task automatic push_pkt(int src, int nbeats, logic [BW-1:0] hkeep);
        hdr_t  h;
        beat_t b;
        h.d = $urandom; h.k = hkeep; h.c = CW'($urandom_range(0, BW - 1));
        drv_hdr_q[src].push_back(h);
        exp_hdr_q[src].push_back(h);
        for (int i = 0; i < nbeats; i++) begin
            b.d = $urandom;
            b.l = (i == nbeats - 1);
            b.k = b.l ? BW'($urandom) : {BW{1'b1}};
            drv_beat_q[src].push_back(b);
            exp_beat_q[src].push_back(b);
        end
    endtask

    // Source driver: holds valid until handshake, pops on accepted beats.
    initial begin
        logic [NS-1:0] hs_h, hs_d, hv, dv;
        hv = '0; dv = '0;
        forever begin
            @(negedge clk);
            hs_h = s_valid_insert & s_ready_insert;
            hs_d = s_valid_in & s_ready_in;
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (hs_h[i] && drv_hdr_q[i].size() > 0) begin
                    void'(drv_hdr_q[i].pop_front()); hv[i] = 1'b0;
                end
                if (hs_d[i] && drv_beat_q[i].size() > 0) begin
                    void'(drv_beat_q[i].pop_front()); dv[i] = 1'b0;
                end
                hv[i] = (hv[i] || $urandom_range(0, 99) >= gap_pct) && drv_hdr_q[i].size() > 0;
                dv[i] = (dv[i] || $urandom_range(0, 99) >= gap_pct) && drv_beat_q[i].size() > 0;
                s_valid_insert[i] = hv[i];
                s_valid_in[i]     = dv[i];
                if (hv[i]) begin
                    s_data_insert[i*DW +: DW]     = drv_hdr_q[i][0].d;
                    s_keep_insert[i*BW +: BW]     = drv_hdr_q[i][0].k;
                    s_byte_insert_cnt[i*CW +: CW] = drv_hdr_q[i][0].c;
                end
                if (dv[i]) begin
                    s_data_in[i*DW +: DW] = drv_beat_q[i][0].d;
                    s_keep_in[i*BW +: BW] = drv_beat_q[i][0].k;
                    s_last_in[i]          = drv_beat_q[i][0].l;
                end else begin
                    s_data_in[i*DW +: DW] = $urandom;
                    s_last_in[i]          = 1'($urandom);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ready_in     = ($urandom_range(0, 99) < rin_pct);
            ready_insert = ($urandom_range(0, 99) < rins_pct) && !rins_block;
        end
    end

    // Monitor: compares every cycle against the model and pops expected transfers.
    initial begin
        logic [NS-1:0] mask;
        hdr_t  eh;
        beat_t eb;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("grant_valid", grant_valid, m_busy);
                mask = m_busy ? NS'(1 << m_gid) : '0;
                chk("s_ready_in_leak", s_ready_in & ~mask, 0);
                chk("s_ready_insert_leak", s_ready_insert & ~mask, 0);
                if (m_busy) begin
                    chk("grant_id", grant_id, m_gid);
                    if (m_new) begin grant_log.push_back(m_gid); m_new = 1'b0; end
                    chk("valid_insert", valid_insert, s_valid_insert[m_gid] && !m_hdr_done);
                    chk("valid_in", valid_in, s_valid_in[m_gid] && !m_dat_done);
                    chk("s_ready_insert", s_ready_insert[m_gid], ready_insert && !m_hdr_done);
                    chk("s_ready_in", s_ready_in[m_gid], ready_in && !m_dat_done);
                    if (valid_insert && ready_insert) begin
                        if (exp_hdr_q[m_gid].size() == 0) chk("hdr_unexpected", 1, 0);
                        else begin
                            eh = exp_hdr_q[m_gid].pop_front();
                            chk("hdr_payload", {data_insert, keep_insert, byte_insert_cnt}, eh);
                        end
                        m_hdr_done = 1'b1;
                    end
                    if (valid_in && ready_in) begin
                        if (exp_beat_q[m_gid].size() == 0) chk("beat_unexpected", 1, 0);
                        else begin
                            eb = exp_beat_q[m_gid].pop_front();
                            chk("beat_payload", {data_in, keep_in, last_in}, eb);
                        end
                        m_beats++;
                        if (last_in) m_dat_done = 1'b1;
                    end
                    if (m_hdr_done && m_dat_done) begin
                        $display("[TB] packet src=%0d beats=%0d complete at %0t", m_gid, m_beats, $time);
                        m_busy = 1'b0;
                    end
                end else begin
                    chk("idle_valid_in", valid_in, 0);
                    chk("idle_valid_insert", valid_insert, 0);
                    if (|s_valid_insert) begin
                        m_gid = pick(s_valid_insert, m_rr);
                        m_rr = (m_gid + 1) % NS;
                        m_busy = 1'b1; m_new = 1'b1;
                        m_hdr_done = 1'b0; m_dat_done = 1'b0; m_beats = 0;
                    end
                end
            end
        end
    end

    function automatic bit all_drained();
        for (int i = 0; i < NS; i++)
            if (exp_beat_q[i].size() != 0 || exp_hdr_q[i].size() != 0) return 1'b0;
        return !m_busy;
    endfunction

    task automatic wait_drain(string name, int budget);
        int c;
        c = 0;
        while (!all_drained() && c < budget) begin @(negedge clk); #1; c++; end
        chk({name, "_drain_timeout"}, c >= budget, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int c;
        repeat (3) @(negedge clk);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_valids", {valid_in, valid_insert}, 0);
        chk("rst_readies", {s_ready_in, s_ready_insert}, 0);
        @(posedge clk); #3; rst_n = 1'b1;

        // Source 2 alone, 3-beat packet, header keep 0011.
        push_pkt(2, 3, 4'b0011);
        wait_drain("src2", 200);
        chk("src2_grant_count", grant_log.size(), 1);
        chk("src2_grant_id", (grant_log.size() > 0) ? grant_log[0] : -1, 2);

        // Reset after beat 2 of a 4-beat packet.
        push_pkt(1, 4, 4'hF);
        c = 0;
        while (exp_beat_q[1].size() > 2 && c < 200) begin @(negedge clk); #1; c++; end
        chk("rst_mid_wait_timeout", c >= 200, 0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valids", {valid_in, valid_insert}, 0);
        chk("rst_mid_readies", {s_ready_in, s_ready_insert}, 0);
        chk("rst_mid_grant_valid", grant_valid, 0);
        for (int i = 0; i < NS; i++) begin
            drv_beat_q[i].delete(); drv_hdr_q[i].delete();
            exp_beat_q[i].delete(); exp_hdr_q[i].delete();
        end
        m_busy = 1'b0; m_new = 1'b0; m_rr = 0; m_hdr_done = 1'b0; m_dat_done = 1'b0;
        repeat (2) @(posedge clk);
        #3; rst_n = 1'b1;

        // All sources request together, twice.
        for (int round = 0; round < 2; round++) begin
            grant_log.delete();
            for (int s = 0; s < NS; s++) push_pkt(s, 2, 4'hF);
            wait_drain("all4", 400);
            chk($sformatf("order_r%0d_count", round), grant_log.size(), NS);
            for (int i = 0; i < NS; i++)
                chk($sformatf("order_r%0d_%0d", round, i), (grant_log.size() > i) ? grant_log[i] : -1, i);
        end

        // Source 1 data ahead of its header; others request meanwhile.
        grant_log.delete();
        rins_block = 1'b1;
        push_pkt(1, 3, 4'hF);
        c = 0;
        while (!grant_valid && c < 50) begin @(negedge clk); c++; end
        chk("early_data_grant_timeout", c >= 50, 0);
        push_pkt(0, 2, 4'hF);
        push_pkt(3, 1, 4'hF);
        repeat (5) @(posedge clk);
        #1;
        chk("early_data_grant_held", grant_valid, 1);
        chk("early_data_grant_id", grant_id, 1);
        rins_block = 1'b0;
        wait_drain("early_data", 400);
        chk("early_data_first", (grant_log.size() > 0) ? grant_log[0] : -1, 1);

        // Random traffic with a sparse downstream ready.
        gap_pct = 30; rin_pct = 20; rins_pct = 50;
        for (int p = 0; p < 24; p++) begin
            push_pkt($urandom_range(0, NS - 1), $urandom_range(1, 4), BW'($urandom));
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end
        wait_drain("random", 8000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
